// File: rtl/vc_switch_arbiter.sv
// Packet-granular round-robin arbiter for the switch output shared by the VC buffers.
// A VC owns the switch from its head flit until its tail flit is forwarded; forwarding is credit-gated.
module vc_switch_arbiter #(
    parameter int NUM_VC      = 2,
    parameter int CREDIT_W    = 3,
    parameter int MAX_CREDITS = 4,
    localparam int SEL_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_VC-1:0]   vc_req,
    input  logic [NUM_VC-1:0]   vc_head,
    input  logic [NUM_VC-1:0]   vc_tail,
    input  logic                credit_return,
    output logic [NUM_VC-1:0]   grant,
    output logic [SEL_W-1:0]    sel_vc,
    output logic                fire,
    output logic [CREDIT_W-1:0] credits,
    output logic                busy,
    output logic                credit_err
);

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);
    localparam logic [CREDIT_W-1:0] ONE_C = CREDIT_W'(1);
    localparam logic [SEL_W-1:0]    LAST_RST = SEL_W'(NUM_VC - 1);

    // busy is the state itself, so the FSM state is always visible on a port.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_VC-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                credit_err_q, credit_err_d;

    logic [NUM_VC-1:0]   cand;
    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic [SEL_W-1:0]    scan_idx;
    int                  scan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            sel_q        <= '0;
            last_q       <= LAST_RST;
            credits_q    <= MAX_C;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Round-robin scan starts just after the last packet owner.
    always_comb begin
        cand       = vc_req & vc_head;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_VC; k++) begin
            scan = int'(last_q) + k;
            if (scan >= NUM_VC) begin
                scan = scan - NUM_VC;
            end
            scan_idx = SEL_W'(scan);
            if (!pick_found && cand[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        last_d       = last_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;

        case (state_q)
            IDLE: begin
                if (pick_found && (credits_q != '0)) begin
                    state_d = ACTIVE;
                    grant_d = NUM_VC'(1) << pick_idx;
                    sel_d   = pick_idx;
                end
            end
            ACTIVE: begin
                if (fire && vc_tail[sel_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A return while already full means downstream and this counter disagree.
        if (credit_return && (credits_q == MAX_C)) begin
            credit_err_d = 1'b1;
        end
        case ({fire, credit_return})
            2'b10:   credits_d = credits_q - ONE_C;
            2'b01:   if (credits_q != MAX_C) credits_d = credits_q + ONE_C;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        busy       = (state_q == ACTIVE);
        fire       = (state_q == ACTIVE) && vc_req[sel_q] && (credits_q != '0);
        grant      = grant_q;
        sel_vc     = sel_q;
        credits    = credits_q;
        credit_err = credit_err_q;
    end

endmodule

// File: tb/tb_vc_switch_arbiter.sv
// Bench for vc_switch_arbiter: directed flit vectors, an integer-level packet model
// compared every cycle, and hand-computed literal checkpoints.
module tb_vc_switch_arbiter;

    localparam int NV   = 2;
    localparam int CW   = 3;
    localparam int MAXC = 4;

    logic          clk;
    logic          rst;
    logic [NV-1:0] vc_req;
    logic [NV-1:0] vc_head;
    logic [NV-1:0] vc_tail;
    logic          credit_return;
    logic [NV-1:0] grant;
    logic [0:0]    sel_vc;
    logic          fire;
    logic [CW-1:0] credits;
    logic          busy;
    logic          credit_err;

    int checks;
    int errors;

    vc_switch_arbiter #(
        .NUM_VC(NV),
        .CREDIT_W(CW),
        .MAX_CREDITS(MAXC)
    ) dut (
        .clk(clk),
        .reset(rst),
        .vc_req(vc_req),
        .vc_head(vc_head),
        .vc_tail(vc_tail),
        .credit_return(credit_return),
        .grant(grant),
        .sel_vc(sel_vc),
        .fire(fire),
        .credits(credits),
        .busy(busy),
        .credit_err(credit_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    int m_busy, m_owner, m_last, m_credits, m_err;
    int m_fire, m_pick, m_next_credits;

    function automatic int model_pick(input logic [NV-1:0] req, input logic [NV-1:0] head,
                                      input int last);
        int idx;
        for (int k = 1; k <= NV; k++) begin
            idx = (last + k) % NV;
            if (req[idx] && head[idx]) return idx;
        end
        return -1;
    endfunction

    always_comb begin
        m_fire = (m_busy != 0 && vc_req[m_owner] && m_credits > 0) ? 1 : 0;
        m_pick = model_pick(vc_req, vc_head, m_last);
        m_next_credits = m_credits + (credit_return ? 1 : 0) - m_fire;
        if (m_next_credits > MAXC) m_next_credits = MAXC;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 0;
            m_owner   <= 0;
            m_last    <= NV - 1;
            m_credits <= MAXC;
            m_err     <= 0;
        end else begin
            m_credits <= m_next_credits;
            if (credit_return && m_credits == MAXC) m_err <= 1;
            if (m_busy == 0) begin
                if (m_pick >= 0 && m_credits > 0) begin
                    m_busy  <= 1;
                    m_owner <= m_pick;
                end
            end else if (m_fire != 0 && vc_tail[m_owner]) begin
                m_busy <= 0;
                m_last <= m_owner;
            end
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_grant", int'(grant), (m_busy != 0) ? (1 << m_owner) : 0);
            chk("cmp_sel_vc", int'(sel_vc), m_owner);
            chk("cmp_fire", int'(fire), m_fire);
            chk("cmp_credits", int'(credits), m_credits);
            chk("cmp_busy", int'(busy), m_busy);
            chk("cmp_credit_err", int'(credit_err), m_err);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [NV-1:0] req, input logic [NV-1:0] head,
                        input logic [NV-1:0] tail, input logic cr);
        @(posedge clk);
        #1;
        vc_req        = req;
        vc_head       = head;
        vc_tail       = tail;
        credit_return = cr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        vc_req        = '0;
        vc_head       = '0;
        vc_tail       = '0;
        credit_return = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        vc_req        = '0;
        vc_head       = '0;
        vc_tail       = '0;
        credit_return = 1'b0;
        #2;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_credits", int'(credits), 4);
        chk("rst_fire", int'(fire), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 3-flit packet on VC0
        step(2'b01, 2'b01, 2'b00, 1'b0); chk("t1_c0_grant", int'(grant), 0);
        step(2'b01, 2'b01, 2'b00, 1'b0); chk("t1_c1_grant", int'(grant), 1);
        chk("t1_c1_fire", int'(fire), 1); chk("t1_c1_credits", int'(credits), 4);
        step(2'b01, 2'b00, 2'b00, 1'b0); chk("t1_c2_credits", int'(credits), 3);
        step(2'b01, 2'b00, 2'b01, 1'b0); chk("t1_c3_fire", int'(fire), 1);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t1_c4_grant", int'(grant), 0);
        chk("t1_c4_busy", int'(busy), 0); chk("t1_c4_credits", int'(credits), 1);

        // two heads, round robin, single-flit on VC1, no grant at zero credits
        do_reset();
        step(2'b11, 2'b11, 2'b10, 1'b0); chk("t2_c0_grant", int'(grant), 0);
        step(2'b11, 2'b11, 2'b10, 1'b0); chk("t2_c1_grant", int'(grant), 1);
        step(2'b11, 2'b10, 2'b11, 1'b0); chk("t2_c2_fire", int'(fire), 1);
        step(2'b11, 2'b11, 2'b10, 1'b0); chk("t2_c3_busy", int'(busy), 0);
        step(2'b11, 2'b11, 2'b10, 1'b0); chk("t2_c4_grant", int'(grant), 2);
        chk("t2_c4_sel", int'(sel_vc), 1); chk("t2_c4_fire", int'(fire), 1);
        step(2'b01, 2'b01, 2'b01, 1'b0); chk("t2_c5_grant", int'(grant), 0);
        chk("t2_c5_sel_hold", int'(sel_vc), 1);
        step(2'b01, 2'b01, 2'b01, 1'b0); chk("t2_c6_grant", int'(grant), 1);
        step(2'b01, 2'b01, 2'b01, 1'b0); chk("t2_c7_credits", int'(credits), 0);
        step(2'b01, 2'b01, 2'b01, 1'b1); chk("t2_c8_nogrant", int'(grant), 0);
        step(2'b01, 2'b01, 2'b01, 1'b0); chk("t2_c9_credits", int'(credits), 1);
        step(2'b01, 2'b01, 2'b01, 1'b0); chk("t2_c10_grant", int'(grant), 1);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t2_c11_credits", int'(credits), 0);

        // credit stall on a 6-flit VC1 packet
        do_reset();
        step(2'b10, 2'b10, 2'b00, 1'b0);
        step(2'b10, 2'b10, 2'b00, 1'b0); chk("t3_c1_grant", int'(grant), 2);
        repeat (3) step(2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b10, 2'b00, 2'b00, 1'b0); chk("t3_c5_fire", int'(fire), 0);
        chk("t3_c5_credits", int'(credits), 0); chk("t3_c5_grant", int'(grant), 2);
        step(2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b10, 2'b00, 2'b00, 1'b1); chk("t3_c7_fire", int'(fire), 0);
        step(2'b10, 2'b00, 2'b00, 1'b0); chk("t3_c8_fire", int'(fire), 1);
        step(2'b10, 2'b00, 2'b10, 1'b0); chk("t3_c9_credits", int'(credits), 0);
        step(2'b10, 2'b00, 2'b10, 1'b1);
        step(2'b10, 2'b00, 2'b10, 1'b0); chk("t3_c11_fire", int'(fire), 1);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t3_c12_busy", int'(busy), 0);

        // fire and credit_return together
        do_reset();
        step(2'b01, 2'b01, 2'b00, 1'b0);
        step(2'b01, 2'b01, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b1); chk("t4_c3_credits", int'(credits), 2);
        step(2'b01, 2'b00, 2'b01, 1'b0); chk("t4_c4_credits", int'(credits), 2);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t4_c5_credits", int'(credits), 1);

        // overflow return is sticky until reset
        do_reset();
        step(2'b00, 2'b00, 2'b00, 1'b1); chk("t5_err_before", int'(credit_err), 0);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t5_credits_sat", int'(credits), 4);
        chk("t5_err_set", int'(credit_err), 1);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t5_err_sticky", int'(credit_err), 1);
        do_reset();
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t5_err_cleared", int'(credit_err), 0);

        // asynchronous reset mid-packet
        do_reset();
        step(2'b01, 2'b01, 2'b00, 1'b0);
        step(2'b01, 2'b01, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b0); chk("t6_pre_credits", int'(credits), 1);
        chk("t6_pre_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_grant", int'(grant), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_credits", int'(credits), 4);
        chk("t6_async_fire", int'(fire), 0);
        vc_req = '0;
        vc_head = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("t6_after_grant", int'(grant), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_switch_arbiter.md
Name: vc_switch_arbiter

Overview:
- Sequences the router's shared switch output between virtual-channel buffers.
- Performs wormhole-style, packet-granular round-robin arbitration: ownership is granted on a head flit and held until the owner's tail flit is forwarded.
- Tracks downstream buffer credits and stalls forwarding when credits are exhausted.
- Sits between the VC buffers and the switch, driving the switch's VC select and the per-VC dequeue grant.

Parameters:
- NUM_VC, 2, number of virtual channels arbitrated (≥2).
- CREDIT_W, 3, width of the credit counter.
- MAX_CREDITS, 4, downstream buffer depth; credit counter reset value (must be < 2^CREDIT_W).
- SEL_W (localparam), max(1, clog2(NUM_VC)), width of the VC index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- vc_req  in  NUM_VC  VC i has a flit at its head; held until forwarded.
- vc_head  in  NUM_VC  flit at VC i is a head flit (valid only with vc_req[i]).
- vc_tail  in  NUM_VC  flit at VC i is a tail flit (head and tail may both be set for a single-flit packet).
- credit_return  in  1  downstream freed one buffer slot this cycle.
- grant  out  NUM_VC  registered one-hot ownership; zero when idle.
- sel_vc  out  SEL_W  registered index of the owning VC; drives the switch mux.
- fire  out  1  combinational; a flit from VC sel_vc is forwarded this cycle.
- credits  out  CREDIT_W  registered current credit count.
- busy  out  1  registered; a packet holds the switch.
- credit_err  out  1  sticky; a credit was returned while the count was already at MAX_CREDITS.

Behaviour:
- Reset values:
  - grant = 0, sel_vc = 0, busy = 0.
  - credits = MAX_CREDITS, credit_err = 0.
  - Round-robin pointer last = NUM_VC-1, so VC0 has first priority.
  - fire = 0, because it depends on busy.
- Reset asserted mid-packet aborts ownership immediately and restores all reset values; there is no partial-packet recovery.
- FSM states: IDLE (busy = 0) and ACTIVE (busy = 1).
- IDLE:
  - Candidates are VCs with vc_req[i] & vc_head[i].
  - If any candidate exists and credits ≠ 0, pick the first candidate scanning last+1, last+2, … modulo NUM_VC.
  - Next cycle: state = ACTIVE, grant = onehot(pick), sel_vc = pick.
  - Requests without head are ignored in IDLE.
  - With credits = 0, stay IDLE; no grant is issued.
  - Grant latency is 1 cycle from the head request.
- ACTIVE:
  - fire = busy & vc_req[sel_vc] & (credits ≠ 0).
  - A VC holds its flit until it observes fire with grant[i] = 1; the flit dequeues on that edge.
  - fire & vc_tail[sel_vc]: next cycle state = IDLE, grant = 0, last = sel_vc.
  - An owner flit with vc_head set while ACTIVE is treated as a body flit.
  - Non-owner requests, including heads, are ignored until IDLE.
  - Minimum cycles per packet: 1 grant cycle + N flit cycles.
  - No back-to-back grant in the tail cycle: the next arbitration happens in the cycle after return to IDLE.
- Credits:
  - fire only → credits − 1.
  - credit_return only → credits + 1.
  - Both in the same cycle → unchanged.
  - credit_return at MAX_CREDITS → count saturates and credit_err sets until reset.
  - credits never underflow, since fire requires credits ≠ 0.
  - credits = 0 while ACTIVE → fire = 0 (stall); grant is retained and the packet is not preempted.
- grant is always one-hot or zero.
- sel_vc holds its last value while IDLE.

Test Plan:
- Reset, then VC0 sends a 3-flit packet (head, body, tail) with credits = 4:
  - grant = 01 at cycle 1.
  - fire in cycles 1–3.
  - credits 4→1.
  - grant = 00 and busy = 0 at cycle 4.
- VC0 and VC1 both hold head flits from IDLE after reset:
  - VC0 is granted first.
  - After VC0's tail, VC1 is granted (sel_vc = 1) one cycle after IDLE is re-entered, even though VC0 re-requests with a new head.
- Credit stall: MAX_CREDITS = 4, VC1 sends a 6-flit packet with no credit_return:
  - fire for 4 flits, then credits = 0 and fire = 0 with grant held at 10.
  - One credit_return pulse → next flit fires and credits returns to 0.
- Simultaneous fire and credit_return with credits = 2 → credits stays 2.
- Extra credit_return with credits = 4 → credits stays 4 and credit_err = 1 until reset.
- Single-flit packet (head = tail = 1) on VC1:
  - Grant, one fire, then return to IDLE.
- Separately, assert reset mid-packet while ACTIVE with credits = 1:
  - Outputs asynchronously become grant = 0, busy = 0, credits = 4.
